// File: rtl/fifo_pkg.sv
// Shared sizing and parity helpers for the sync_fifo slice.
package fifo_pkg;

  localparam int unsigned PARITY_MAX_W = 1024;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra wrap bit above the address bits.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return addr_w(depth) + 1;
  endfunction

  // Zero-extended inputs keep the XOR reduction exact for any width <= PARITY_MAX_W.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one write port, one registered read port (old data on same-address read/write).
module sync_fifo_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered flags, occupancy count and sticky error flags.
// Define SYNC_FIFO_PARITY_EN to store an even-parity bit per entry and check it on read.
module sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rdata_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
`ifdef SYNC_FIFO_PARITY_EN
 ,output logic                     parity_err,
  output logic                     parity_err_sticky
`endif
);
  import fifo_pkg::*;

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned PTR_W  = ptr_w(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
`ifdef SYNC_FIFO_PARITY_EN
  localparam int unsigned MEM_W  = WIDTH + 1;
`else
  localparam int unsigned MEM_W  = WIDTH;
`endif
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LVL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, af_q, ae_q;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             valid_q;
  logic             rd_acc, wr_acc;
  logic [MEM_W-1:0] mem_wdata, mem_rdata;

  // A write into a full FIFO is legal only because the same-cycle read frees a slot.
  always_comb begin
    rd_acc   = rd_en & ~empty_q;
    wr_acc   = wr_en & (~full_q | rd_en);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    ovf_d    = (wr_en & full_q & ~rd_en) | (ovf_q & ~clr_err);
    unf_d    = (rd_en & empty_q) | (unf_q & ~clr_err);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= rd_acc;
    end
  end

`ifdef SYNC_FIFO_PARITY_EN
  logic par_mis;
  logic par_sticky_q;

  assign mem_wdata = {even_parity(PARITY_MAX_W'(wdata)), wdata};
  assign par_mis   = even_parity(PARITY_MAX_W'(mem_rdata[WIDTH-1:0])) ^ mem_rdata[WIDTH];
  assign parity_err        = valid_q & par_mis;
  assign parity_err_sticky = par_sticky_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) par_sticky_q <= 1'b0;
    else      par_sticky_q <= parity_err | (par_sticky_q & ~clr_err);
  end
`else
  assign mem_wdata = wdata;
`endif

  sync_fifo_ram #(
    .DW    (MEM_W),
    .DEPTH (DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (mem_wdata),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  assign rdata        = mem_rdata[WIDTH-1:0];
  assign rdata_valid  = valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF_LVL = DEPTH - 2;
  localparam int unsigned AE_LVL = 2;
  localparam int unsigned CW     = 5;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             rdata_valid, full, empty, almost_full, almost_empty;
  logic [CW-1:0]    count;
  logic             overflow, underflow;
`ifdef SYNC_FIFO_PARITY_EN
  logic             parity_err, parity_err_sticky;
`endif

  int checks = 0;
  int fails  = 0;

  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_valid, m_ovf, m_unf;
  logic [11:0]      dut_status;

  always #5 CLK = ~CLK;

  sync_fifo #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef SYNC_FIFO_PARITY_EN
   ,.parity_err        (parity_err),
    .parity_err_sticky (parity_err_sticky)
`endif
  );

  assign dut_status = {full, empty, almost_full, almost_empty, count, overflow, underflow, rdata_valid};

  function automatic logic [11:0] exp_status();
    int unsigned n;
    n = m_q.size();
    return {n == DEPTH, n == 0, n >= AF_LVL, n <= AE_LVL, CW'(n), m_ovf, m_unf, m_valid};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rdata = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Drive one cycle of stimulus and advance the model from the pre-edge state.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
    int unsigned n;
    logic is_full, is_empty, racc, wacc;
    wr_en = w; wdata = d; rd_en = r; clr_err = c;
    n        = m_q.size();
    is_full  = (n == DEPTH);
    is_empty = (n == 0);
    racc     = r && !is_empty;
    wacc     = w && (!is_full || r);
    m_ovf    = (w && is_full && !r) || (m_ovf && !c);
    m_unf    = (r && is_empty) || (m_unf && !c);
    if (racc) begin
      m_rdata = m_q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wacc) m_q.push_back(d);
    @(posedge CLK);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge CLK);
    #1;
    checks++;
    if (dut_status !== 12'h500) begin
      fails++; $display("FAIL reset_status got %h exp %h", dut_status, 12'h500);
    end
    checks++;
    if (rdata !== '0) begin
      fails++; $display("FAIL reset_rdata got %h exp 00", rdata);
    end
    RST = 1'b1;
    model_reset();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (dut_status !== exp_status()) begin
        fails++; $display("FAIL fill_status[%0d] got %h exp %h", i, dut_status, exp_status());
      end
      checks++;
      if (almost_full !== (i + 1 >= 14)) begin
        fails++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i + 1 >= 14));
      end
    end
    checks++;
    if ({full, count, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      fails++; $display("FAIL full_after_16 got full=%b count=%0d ovf=%b exp 1/16/0", full, count, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rdata_valid !== 1'b1 || rdata !== 8'(i)) begin
        fails++; $display("FAIL drain_data[%0d] got %h v=%b exp %h v=1", i, rdata, rdata_valid, 8'(i));
      end
      checks++;
      if (almost_empty !== (15 - i <= 2)) begin
        fails++; $display("FAIL drain_ae[%0d] got %b exp %b", i, almost_empty, (15 - i <= 2));
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== '0) begin
      fails++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count);
    end
  endtask

  task automatic test_full_rw();
    logic [WIDTH-1:0] oldest;
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    oldest = m_q[0];
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++;
    if ({rdata, rdata_valid, count, full, overflow} !== {oldest, 1'b1, 5'd16, 1'b1, 1'b0}) begin
      fails++; $display("FAIL full_rw got rdata=%h v=%b cnt=%0d full=%b ovf=%b exp %h/1/16/1/0",
                        rdata, rdata_valid, count, full, overflow, oldest);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rdata !== m_rdata || dut_status !== exp_status()) begin
        fails++; $display("FAIL full_rw_drain[%0d] got %h/%h exp %h/%h", i, rdata, dut_status, m_rdata, exp_status());
      end
    end
    checks++;
    if (rdata !== 8'hAA) begin
      fails++; $display("FAIL full_rw_last got %h exp aa", rdata);
    end
  endtask

  task automatic test_empty_rw();
    step(1'b1, 8'h55, 1'b1, 1'b0);
    checks++;
    if ({underflow, rdata_valid, count} !== {1'b1, 1'b0, 5'd1}) begin
      fails++; $display("FAIL empty_rw got unf=%b v=%b cnt=%0d exp 1/0/1", underflow, rdata_valid, count);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rdata !== 8'h55 || rdata_valid !== 1'b1) begin
      fails++; $display("FAIL empty_rw_read got %h v=%b exp 55 v=1", rdata, rdata_valid);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (dut_status !== exp_status()) begin
      fails++; $display("FAIL unf_clear got %h exp %h", dut_status, exp_status());
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      fails++; $display("FAIL ovf_set got ovf=%b cnt=%0d exp 1/16", overflow, count);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_clear got %b exp 0", overflow);
    end
    step(1'b1, 8'h66, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      fails++; $display("FAIL ovf_set_wins got ovf=%b cnt=%0d exp 1/16", overflow, count);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rdata !== m_rdata || dut_status !== exp_status()) begin
        fails++; $display("FAIL ovf_drain[%0d] got %h/%h exp %h/%h", i, rdata, dut_status, m_rdata, exp_status());
      end
    end
  endtask

  task automatic test_random_wrap();
    for (int i = 0; i < 120; i++) begin
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 10);
      checks++;
      if (rdata !== m_rdata || dut_status !== exp_status()) begin
        fails++; $display("FAIL random[%0d] got %h/%h exp %h/%h", i, rdata, dut_status, m_rdata, exp_status());
      end
    end
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h99;
    #3 RST = 1'b0;
    #1;
    checks++;
    if (dut_status !== 12'h500 || rdata !== '0) begin
      fails++; $display("FAIL mid_reset_async got %h/%h exp 500/00", dut_status, rdata);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (dut_status !== 12'h500 || rdata !== '0) begin
      fails++; $display("FAIL mid_reset_held got %h/%h exp 500/00", dut_status, rdata);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    RST = 1'b1;
    model_reset();
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rdata !== 8'h3C || dut_status !== exp_status()) begin
      fails++; $display("FAIL post_reset got %h/%h exp 3c/%h", rdata, dut_status, exp_status());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_overflow();
    test_random_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
